// File: rtl/reg_file_dumper_if.sv
// Output word stream of the register-file dumper: one register per transfer.
// Latency: n/a (wires only).
// Backpressure: valid/ready; a word is held stable while out_valid=1 and out_ready=0.
//
// Signals:
//   out_valid  master->slave  word present
//   out_ready  slave->master  downstream accepts the word
//   out_addr   master->slave  register index of the word
//   out_data   master->slave  register value of the word
interface reg_file_dumper_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  out_valid;
  logic                  out_ready;
  logic [ADDR_WIDTH-1:0] out_addr;
  logic [DATA_WIDTH-1:0] out_data;

  modport master (
    output out_valid,
    output out_addr,
    output out_data,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_addr,
    input  out_data,
    output out_ready
  );
endinterface

// File: rtl/reg_file_dumper.sv
// Walks register addresses 0..NUM_REGS-1, streams each word out and sums them.
// Latency: 2 cycles per word (FETCH + SEND), done pulses one cycle after the last handshake.
// Backpressure: SEND holds word, index and checksum until out_ready; start ignored while busy.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             one-cycle dump request, honoured only in IDLE
//   busy, done        FETCH/SEND indicator, one-cycle completion pulse
//   rf_raddr/rf_rdata combinational register-file read port
//   out_if (master)   out_valid/out_ready/out_addr/out_data word stream
//   checksum          mod-2^DATA_WIDTH sum of words handshaken since last start
module reg_file_dumper #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_REGS   = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] rf_raddr,
  input  logic [DATA_WIDTH-1:0] rf_rdata,
  reg_file_dumper_if.master     out_if,
  output logic [DATA_WIDTH-1:0] checksum
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_REGS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_SEND,
    S_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [ADDR_WIDTH-1:0] out_addr_q, out_addr_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [DATA_WIDTH-1:0] checksum_q, checksum_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  out_valid_q, out_valid_d;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    out_addr_d = out_addr_q;
    out_data_d = out_data_q;
    checksum_d = checksum_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_FETCH;
          idx_d      = '0;
          checksum_d = '0;
        end
      end
      S_FETCH: begin
        out_data_d = rf_rdata;
        out_addr_d = idx_q;
        state_d    = S_SEND;
      end
      S_SEND: begin
        if (out_valid_q && out_if.out_ready) begin
          checksum_d = checksum_q + out_data_q;
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_FETCH;
          end
        end
      end
      S_DONE: begin
        // Clearing idx here keeps rf_raddr at 0 throughout IDLE.
        idx_d   = '0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
    endcase

    // Status outputs are registered copies of the next state, so they
    // line up exactly with the state they describe.
    busy_d      = (state_d == S_FETCH) || (state_d == S_SEND);
    done_d      = (state_d == S_DONE);
    out_valid_d = (state_d == S_SEND);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
      checksum_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      out_addr_q  <= out_addr_d;
      out_data_q  <= out_data_d;
      checksum_q  <= checksum_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign busy             = busy_q;
  assign done             = done_q;
  assign rf_raddr         = idx_q;
  assign checksum         = checksum_q;
  assign out_if.out_valid = out_valid_q;
  assign out_if.out_addr  = out_addr_q;
  assign out_if.out_data  = out_data_q;

endmodule

// File: tb/tb_reg_file_dumper.sv
// Bench for reg_file_dumper: register-file model, randomized ready, scoreboard of expected words.
// Latency: checks the 65-cycle full dump with ready held high.
// Backpressure: random and forced stalls on out_ready; start/rst injected mid-dump.
module tb_reg_file_dumper;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 32;

  logic          clk;
  logic          rst;
  logic          start;
  logic          busy;
  logic          done;
  logic [AW-1:0] rf_raddr;
  logic [DW-1:0] rf_rdata;
  logic [DW-1:0] checksum;
  logic [DW-1:0] rf_mem [NR];

  int n_tests;
  int n_fail;

  reg_file_dumper_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) out_if ();

  reg_file_dumper #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .NUM_REGS  (NR)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .rf_raddr(rf_raddr),
    .rf_rdata(rf_rdata),
    .out_if  (out_if),
    .checksum(checksum)
  );

  // Register file with a combinational read port.
  assign rf_rdata = rf_mem[rf_raddr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // One full dump from the IDLE cycle in which start is driven. Word order,
  // data and the running checksum come from the bench's own register array.
  // A negative word index disables the corresponding event.
  task automatic dump(input bit rnd_ready, input int stall_word, input int restart_word,
                      input int rst_word, input int wr_word);
    int          exp_idx;
    logic [DW-1:0] exp_sum;
    logic [DW-1:0] full_sum;
    int          cyc;
    int          stall_left;
    bit          restarted;
    bit          finished;
    bit          prev_stall;
    bit          ready;
    exp_idx    = 0;
    exp_sum    = '0;
    stall_left = 5;
    restarted  = 1'b0;
    finished   = 1'b0;
    prev_stall = 1'b0;

    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
    chk("idle_valid", out_if.out_valid, 0);
    chk("idle_raddr", rf_raddr, 0);
    start = 1'b1;
    out_if.out_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    cyc = 1;

    while (!finished && cyc < 400) begin
      start = 1'b0;
      chk("checksum", checksum, exp_sum);
      if (done) begin
        full_sum = '0;
        for (int i = 0; i < NR; i++) full_sum = full_sum + rf_mem[i];
        chk("done_words", exp_idx, NR);
        chk("final_sum", checksum, full_sum);
        chk("done_busy", busy, 0);
        chk("done_valid", out_if.out_valid, 0);
        if (!rnd_ready && stall_word < 0) chk("done_cycle", cyc, 65);
        finished = 1'b1;
      end else begin
        chk("busy", busy, 1);
        if (exp_idx < NR) chk("raddr", rf_raddr, exp_idx);
        if (prev_stall) chk("hold_valid", out_if.out_valid, 1);
        if (out_if.out_valid) begin
          chk("out_addr", out_if.out_addr, exp_idx);
          chk("out_data", out_if.out_data, rf_mem[exp_idx]);
          ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
          if (exp_idx == stall_word && stall_left > 0) begin
            ready = 1'b0;
            stall_left--;
          end
          if (exp_idx == restart_word && !restarted) begin
            start     = 1'b1;
            restarted = 1'b1;
          end
          if (exp_idx == wr_word) rf_mem[5] = 32'hDEAD_BEEF;
          out_if.out_ready = ready;
          prev_stall = !ready;
          if (exp_idx == rst_word) begin
            rst = 1'b1;
          end else if (ready) begin
            exp_sum = exp_sum + rf_mem[exp_idx];
            exp_idx++;
          end
        end else begin
          out_if.out_ready = 1'($urandom_range(0, 1));
          prev_stall = 1'b0;
        end
      end
      @(negedge clk);
      cyc++;
      if (rst) begin
        chk("rst_busy", busy, 0);
        chk("rst_valid", out_if.out_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_checksum", checksum, 0);
        chk("rst_raddr", rf_raddr, 0);
        rst = 1'b0;
        return;
      end
    end
    chk("no_timeout", finished, 1);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    start   = 1'b0;
    out_if.out_ready = 1'b0;
    for (int i = 0; i < NR; i++) rf_mem[i] = 32'(i) * 32'h1111_1111;

    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_valid", out_if.out_valid, 0);
    chk("reset_addr", out_if.out_addr, 0);
    chk("reset_data", out_if.out_data, 0);
    chk("reset_checksum", checksum, 0);
    chk("reset_raddr", rf_raddr, 0);

    // Ready held high: 32 words in order, done in cycle 65.
    dump(1'b0, -1, -1, -1, -1);
    // Five-cycle stall on word 3.
    dump(1'b0, 3, -1, -1, -1);
    // Random ready with a stray start at word 10.
    dump(1'b1, -1, 10, -1, -1);
    // Reset during SEND of word 7, then a clean dump from address 0.
    dump(1'b1, -1, -1, 7, -1);
    // Register 5 rewritten while word 2 is being sent.
    dump(1'b1, -1, -1, -1, 2);
    chk("wr_visible", rf_mem[5], 32'hDEAD_BEEF);

    @(negedge clk);
    chk("end_busy", busy, 0);
    chk("end_done", done, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
